// File: rtl/fixed_linear_pkg.sv
// fixed_linear_pkg: width helpers and fixed-point shift/round/saturate functions for the tiled linear layer.
package fixed_linear_pkg;

    typedef logic signed [63:0] wide_t;

    function automatic int acc_width(input int di0, input int w0, input int k);
        return di0 + w0 + $clog2(k) + 1;
    endfunction

    // Positive result means a left shift is needed to move from from_frac to to_frac.
    function automatic int align_shift(input int to_frac, input int from_frac);
        return to_frac - from_frac;
    endfunction

    // Left shift for sh >= 0, arithmetic (floor) right shift otherwise.
    function automatic wide_t shift_by(input wide_t x, input int sh);
        return sh >= 0 ? x <<< sh : x >>> (-sh);
    endfunction

    // Left shift for sh >= 0, otherwise right shift rounding half-up.
    function automatic wide_t round_shift(input wide_t x, input int sh);
        return sh >= 0 ? x <<< sh : (x + (wide_t'(1) <<< (-sh - 1))) >>> (-sh);
    endfunction

    function automatic wide_t saturate(input wide_t x, input int w);
        wide_t hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        return x > hi ? hi : (x < -hi - wide_t'(1) ? -hi - wide_t'(1) : x);
    endfunction

endpackage

// File: rtl/fixed_linear_requant.sv
// fixed_linear_requant: adds aligned bias to one accumulated sum, rounds and narrows it to the output format.
// Narrowing saturates when FIXED_LINEAR_TILED_SAT_EN is defined, otherwise wraps.
module fixed_linear_requant
    import fixed_linear_pkg::*;
#(
    parameter int HAS_BIAS  = 0,
    parameter int ACC_WIDTH = 19,
    parameter int ACC_FRAC  = 8,
    parameter int B0        = 8,
    parameter int B1        = 4,
    parameter int DO0       = 8,
    parameter int DO1       = 4
) (
    input  logic signed [ACC_WIDTH-1:0] acc_in,
    input  logic        [B0-1:0]        bias,
    output logic        [DO0-1:0]       q
);

    localparam int BSH = align_shift(ACC_FRAC, B1);
    localparam int RSH = align_shift(DO1, ACC_FRAC);

    logic signed [ACC_WIDTH:0] sum;

    // Bias alignment, one-bit-wider sum, round-half-up and narrowing of a single element.
    always_comb begin
        sum = (ACC_WIDTH + 1)'(acc_in)
            + (ACC_WIDTH + 1)'(HAS_BIAS != 0 ? shift_by(wide_t'($signed(bias)), BSH) : wide_t'(0));
`ifdef FIXED_LINEAR_TILED_SAT_EN
        q = DO0'(saturate(round_shift(wide_t'(sum), RSH), DO0));
`else
        q = DO0'(round_shift(wide_t'(sum), RSH));
`endif
    end

endmodule

// File: rtl/fixed_linear_tiled.sv
// fixed_linear_tiled: sequential fixed-point linear layer, P1 rows x PO columns per beat, accumulated over K/P0 beats.
// Define FIXED_LINEAR_TILED_SAT_EN to saturate the output instead of wrapping.
module fixed_linear_tiled
    import fixed_linear_pkg::*;
#(
    parameter int HAS_BIAS                    = 0,
    parameter int DATA_IN_0_PRECISION_0       = 8,
    parameter int DATA_IN_0_PRECISION_1       = 4,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 4,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 2,
    parameter int DATA_IN_0_PARALLELISM_DIM_1 = 2,
    parameter int WEIGHT_PRECISION_0          = 8,
    parameter int WEIGHT_PRECISION_1          = 4,
    parameter int WEIGHT_PARALLELISM_DIM_0    = 2,
    parameter int BIAS_PRECISION_0            = 8,
    parameter int BIAS_PRECISION_1            = 4,
    parameter int DATA_OUT_0_PRECISION_0      = 8,
    parameter int DATA_OUT_0_PRECISION_1      = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic [DATA_IN_0_PRECISION_0*DATA_IN_0_PARALLELISM_DIM_1*DATA_IN_0_PARALLELISM_DIM_0-1:0] data_in_0,
    input  logic data_in_0_valid,
    output logic data_in_0_ready,
    input  logic [WEIGHT_PRECISION_0*WEIGHT_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_0-1:0] weight,
    input  logic weight_valid,
    output logic weight_ready,
    input  logic [BIAS_PRECISION_0*WEIGHT_PARALLELISM_DIM_0-1:0] bias,
    input  logic bias_valid,
    output logic bias_ready,
    output logic [DATA_OUT_0_PRECISION_0*DATA_IN_0_PARALLELISM_DIM_1*WEIGHT_PARALLELISM_DIM_0-1:0] data_out_0,
    output logic data_out_0_valid,
    input  logic data_out_0_ready
);

    localparam int DI0        = DATA_IN_0_PRECISION_0;
    localparam int W0         = WEIGHT_PRECISION_0;
    localparam int K          = DATA_IN_0_TENSOR_SIZE_DIM_0;
    localparam int P0         = DATA_IN_0_PARALLELISM_DIM_0;
    localparam int P1         = DATA_IN_0_PARALLELISM_DIM_1;
    localparam int PO         = WEIGHT_PARALLELISM_DIM_0;
    localparam int NE         = P1 * PO;
    localparam int IN_0_DEPTH = K / P0;
    localparam int ACC_FRAC   = DATA_IN_0_PRECISION_1 + WEIGHT_PRECISION_1;
    localparam int ACC_WIDTH  = acc_width(DI0, W0, K);
    localparam int CW         = IN_0_DEPTH > 1 ? $clog2(IN_0_DEPTH) : 1;

    logic [CW-1:0]                beat_cnt;
    logic signed [ACC_WIDTH-1:0]  acc [NE];
    logic signed [ACC_WIDTH-1:0]  dot [NE];
    logic signed [ACC_WIDTH-1:0]  pre [NE];
    logic [DATA_OUT_0_PRECISION_0*NE-1:0] res;
    logic last, in_rdy, fire, last_fire;

    function automatic logic signed [ACC_WIDTH-1:0] mul(input logic signed [DI0-1:0] a, input logic signed [W0-1:0] b);
        return ACC_WIDTH'(a) * ACC_WIDTH'(b);
    endfunction

    assign last            = beat_cnt == CW'(IN_0_DEPTH - 1);
    assign in_rdy          = !last || ((!data_out_0_valid || data_out_0_ready) && (bias_valid || HAS_BIAS == 0));
    assign data_in_0_ready = in_rdy;
    assign weight_ready    = in_rdy;
    assign fire            = data_in_0_valid && weight_valid && in_rdy;
    assign last_fire       = fire && last;
    assign bias_ready      = (HAS_BIAS != 0) ? last_fire : 1'b1;

    // Per-element dot product of this beat, added to the running sum (restarted on the first beat).
    always_comb begin
        for (int i = 0; i < NE; i++) begin
            dot[i] = '0;
            for (int k = 0; k < P0; k++)
                dot[i] = dot[i] + mul(data_in_0[((i / PO) * P0 + k) * DI0 +: DI0],
                                      weight[((i % PO) * P0 + k) * W0 +: W0]);
            pre[i] = (beat_cnt == '0 ? '0 : acc[i]) + dot[i];
        end
    end

    for (genvar i = 0; i < NE; i++) begin : g_rq
        fixed_linear_requant #(
            .HAS_BIAS (HAS_BIAS),
            .ACC_WIDTH(ACC_WIDTH),
            .ACC_FRAC (ACC_FRAC),
            .B0       (BIAS_PRECISION_0),
            .B1       (BIAS_PRECISION_1),
            .DO0      (DATA_OUT_0_PRECISION_0),
            .DO1      (DATA_OUT_0_PRECISION_1)
        ) u_rq (
            .acc_in(pre[i]),
            .bias  (bias[(i % PO) * BIAS_PRECISION_0 +: BIAS_PRECISION_0]),
            .q     (res[i * DATA_OUT_0_PRECISION_0 +: DATA_OUT_0_PRECISION_0])
        );
    end

    // Beat counter and accumulators advance on every fired beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt <= '0;
            for (int i = 0; i < NE; i++) acc[i] <= '0;
        end else if (fire) begin
            beat_cnt <= last ? '0 : beat_cnt + CW'(1);
            for (int i = 0; i < NE; i++) acc[i] <= pre[i];
        end
    end

    // Output register: loads on the last beat, otherwise clears valid once accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out_0_valid <= 1'b0;
            data_out_0       <= '0;
        end else if (last_fire) begin
            data_out_0_valid <= 1'b1;
            data_out_0       <= res;
        end else if (data_out_0_ready) begin
            data_out_0_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fixed_linear_tiled.sv
// tb_fixed_linear_tiled: directed checks of fixed_linear_tiled against a plain-arithmetic model.
module tb_fixed_linear_tiled;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] data_in_0, weight;
    logic [15:0] bias;
    logic        v0, v1, bias_valid, ordy0, ordy1;
    logic        rdy0, wrdy0, brdy0, ov0, rdy1, wrdy1, brdy1, ov1;
    logic [31:0] out0, out1;

    fixed_linear_tiled #(.HAS_BIAS(0)) dut0 (
        .clk(clk), .rst(rst),
        .data_in_0(data_in_0), .data_in_0_valid(v0), .data_in_0_ready(rdy0),
        .weight(weight), .weight_valid(v0), .weight_ready(wrdy0),
        .bias(bias), .bias_valid(bias_valid), .bias_ready(brdy0),
        .data_out_0(out0), .data_out_0_valid(ov0), .data_out_0_ready(ordy0)
    );

    fixed_linear_tiled #(.HAS_BIAS(1)) dut1 (
        .clk(clk), .rst(rst),
        .data_in_0(data_in_0), .data_in_0_valid(v1), .data_in_0_ready(rdy1),
        .weight(weight), .weight_valid(v1), .weight_ready(wrdy1),
        .bias(bias), .bias_valid(bias_valid), .bias_ready(brdy1),
        .data_out_0(out1), .data_out_0_valid(ov1), .data_out_0_ready(ordy1)
    );

    logic [7:0]  dt [2][4];
    logic [7:0]  wt [2][4];
    logic [7:0]  bv [2];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    int          n_cmp = 0, n_bad = 0, bias_pulses = 0;
    logic        held0 = 1'b0;
    logic [31:0] last0 = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Real-valued meaning: sum of x*w in units of 2^-8, bias in 2^-4, result rounded half-up to 2^-4.
    function automatic logic [7:0] model_elem(input int r, input int c, input bit hb);
        longint s = 0;
        for (int k = 0; k < 4; k++)
            s += longint'($signed(dt[r][k])) * longint'($signed(wt[c][k]));
        if (hb) s += longint'($signed(bv[c])) * 16;
        s = s + 8;
        s = (s >= 0) ? s / 16 : -((-s + 15) / 16);
`ifdef FIXED_LINEAR_TILED_SAT_EN
        if (s > 127) s = 127;
        if (s < -128) s = -128;
`endif
        return s[7:0];
    endfunction

    function automatic logic [31:0] model_tile(input bit hb);
        logic [31:0] v;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                v[(r * 2 + c) * 8 +: 8] = model_elem(r, c, hb);
        return v;
    endfunction

    task automatic fill(input logic [7:0] d, input logic [7:0] w);
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 4; k++) begin
                dt[r][k] = d;
                wt[r][k] = w;
            end
    endtask

    task automatic beat(input bit inst, input int b, input bit last, input int bdelay, output int stalls);
        for (int r = 0; r < 2; r++)
            for (int j = 0; j < 2; j++) begin
                data_in_0[(r * 2 + j) * 8 +: 8] = dt[r][b * 2 + j];
                weight[(r * 2 + j) * 8 +: 8]    = wt[r][b * 2 + j];
            end
        bias = {bv[1], bv[0]};
        if (inst) v1 = 1'b1; else v0 = 1'b1;
        stalls = 0;
        if (last && inst && bdelay == 0) bias_valid = 1'b1;
        @(negedge clk);
        while (!(inst ? rdy1 : rdy0) && stalls <= 200) begin
            stalls++;
            @(posedge clk); #1;
            if (last && inst && stalls == bdelay) bias_valid = 1'b1;
            @(negedge clk);
        end
        if (stalls > 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL beat_timeout: stalled %0d cycles, required under 200", stalls);
        end
        chk(inst ? "weight_ready1" : "weight_ready0", 32'(inst ? wrdy1 : wrdy0), 32'(1));
        @(posedge clk); #1;
        v0 = 1'b0;
        v1 = 1'b0;
        bias_valid = 1'b0;
    endtask

    task automatic send_tile(input bit inst, input int bdelay, output int st);
        int s;
        beat(inst, 0, 1'b0, 0, s);
        beat(inst, 1, 1'b1, bdelay, st);
        if (inst) q1.push_back(model_tile(1'b1)); else q0.push_back(model_tile(1'b0));
    endtask

    // Scoreboard: every accepted output is checked against the model; held outputs must not change.
    always @(negedge clk) begin
        if (!rst) begin
            held0 = 1'b0;
        end else begin
            if (held0) begin
                chk("hold0_data", out0, last0);
                chk("hold0_valid", 32'(ov0), 32'(1));
            end
            if (ov0 && ordy0) begin
                if (q0.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL out0_extra: got %h with nothing expected", out0);
                end else chk("out0", out0, q0.pop_front());
            end
            if (ov1 && ordy1) begin
                if (q1.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL out1_extra: got %h with nothing expected", out1);
                end else chk("out1", out1, q1.pop_front());
            end
            if (brdy1) bias_pulses++;
            held0 = ov0 && !ordy0;
            last0 = out0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int st;
        rst = 1'b0; v0 = 1'b0; v1 = 1'b0; bias_valid = 1'b0; ordy0 = 1'b1; ordy1 = 1'b1;
        data_in_0 = '0; weight = '0; bias = '0;
        bv[0] = 8'h00; bv[1] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid0", 32'(ov0), 32'(0));
        chk("rst_out0", out0, 32'h0);
        chk("rst_valid1", 32'(ov1), 32'(0));
        chk("rst_ready0", 32'(rdy0), 32'(1));
        chk("rst_bias_ready0", 32'(brdy0), 32'(1));
        rst = 1'b1;

        // 1.0 * 1.0 over K=4 -> 4.0
        fill(8'h10, 8'h10);
        send_tile(1'b0, 0, st);
        chk("t1_valid", 32'(ov0), 32'(1));
        chk("t1_out", out0, 32'h40404040);

        // 7.0 * 7.0 * 4 = 196.0 overflows the output
        fill(8'h70, 8'h70);
        send_tile(1'b0, 0, st);
`ifdef FIXED_LINEAR_TILED_SAT_EN
        chk("t2_out", out0, 32'h7F7F7F7F);
`else
        chk("t2_out", out0, 32'h40404040);
`endif

        // 0.5 * 1/16 rounds up to 1/16; -0.5 * 1/16 rounds up to 0
        fill(8'h00, 8'h00);
        dt[0][0] = 8'h08;
        wt[0][0] = 8'h01;
        send_tile(1'b0, 0, st);
        chk("t3_round_pos", out0, 32'h00000001);
        dt[0][0] = 8'hF8;
        send_tile(1'b0, 0, st);
        chk("t3_round_neg", out0, 32'h00000000);
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back tiles under output backpressure
        fill(8'h10, 8'h10);
        ordy0 = 1'b0;
        fork
            begin
                send_tile(1'b0, 0, st);
                fill(8'h20, 8'h10);
                send_tile(1'b0, 0, st);
            end
            begin
                repeat (10) @(posedge clk);
                #1;
                ordy0 = 1'b1;
            end
        join
        chk("t4_stalls", 32'(st), 32'(7));
`ifdef FIXED_LINEAR_TILED_SAT_EN
        chk("t4_tile2", out0, 32'h7F7F7F7F);
`else
        chk("t4_tile2", out0, 32'h80808080);
`endif
        repeat (2) @(posedge clk);
        #1;

        // Bias 1.0 arriving 3 cycles late
        fill(8'h10, 8'h10);
        bv[0] = 8'h10;
        bv[1] = 8'h10;
        bias_pulses = 0;
        send_tile(1'b1, 3, st);
        chk("t5_stalls", 32'(st), 32'(3));
        chk("t5_out", out1, 32'h50505050);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_bias_pulses", 32'(bias_pulses), 32'(1));

        // Reset after the first beat of a tile discards the partial sum
        fill(8'h70, 8'h70);
        beat(1'b0, 0, 1'b0, 0, st);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_rst_valid", 32'(ov0), 32'(0));
        rst = 1'b1;
        fill(8'h10, 8'h10);
        send_tile(1'b0, 0, st);
        chk("t6_out", out0, 32'h40404040);

        repeat (3) @(posedge clk);
        #1;
        chk("q0_drained", 32'(q0.size()), 32'(0));
        chk("q1_drained", 32'(q1.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
